// File: rtl/hqc_rmencod_if.sv
// Handshake and RAM-port bundle for the HQC RM(1,7) encoder.
// The master side is the controller/RAM owner; the slave side is the encoder.
interface hqc_rmencod_if #(
  parameter int IN_AW  = 6,
  parameter int OUT_AW = 8
);
  logic              start_i;
  logic              busy_o;
  logic              done_o;
  logic [7:0]        ram_din_i;
  logic              ram_din_rd_o;
  logic [IN_AW-1:0]  ram_din_addr_o;
  logic              ram_dout_wr_o;
  logic [127:0]      ram_dout_o;
  logic [OUT_AW-1:0] ram_dout_addr_o;

  modport master (
    output start_i, ram_din_i,
    input  busy_o, done_o, ram_din_rd_o, ram_din_addr_o,
           ram_dout_wr_o, ram_dout_o, ram_dout_addr_o
  );

  modport slave (
    input  start_i, ram_din_i,
    output busy_o, done_o, ram_din_rd_o, ram_din_addr_o,
           ram_dout_wr_o, ram_dout_o, ram_dout_addr_o
  );
endinterface

// File: rtl/hqc_rmencod_top.sv
// HQC RM(1,7) encoder: reads N1 message bytes, writes each 128-bit codeword
// MULTIPLICITY times to consecutive output RAM words.
//
// state  | meaning
// IDLE   | waiting for start_i
// RD     | read strobe for byte 0
// LAT    | byte 0 arrives, loaded into msg_q
// WR     | one codeword write per cycle, next byte prefetched at r=0/1
// DONE   | one-cycle done pulse
module hqc_rmencod_top #(
  parameter int PARAM_SECURITY = 128
) (
  input  logic               clk_i,
  input  logic               rst_i,
  hqc_rmencod_if.slave       bus
);
  localparam int MULTIPLICITY = (PARAM_SECURITY == 128) ? 3 : 5;
  localparam int N1     = (PARAM_SECURITY == 128) ? 46 : (PARAM_SECURITY == 192) ? 56 : 90;
  localparam int IN_AW  = (PARAM_SECURITY == 256) ? 7 : 6;
  localparam int OUT_AW = (PARAM_SECURITY == 128) ? 8 : 9;

  localparam logic [2:0]       LAST_REP  = 3'(MULTIPLICITY - 1);
  localparam logic [IN_AW-1:0] LAST_BYTE = IN_AW'(N1 - 1);

  typedef enum logic [2:0] {S_IDLE, S_RD, S_LAT, S_WR, S_DONE} state_t;

  state_t              state_q, state_d;
  logic [IN_AW-1:0]    i_q;
  logic [2:0]          r_q;
  logic [OUT_AW-1:0]   a_q;
  logic [7:0]          msg_q, msg_nxt_q;
  logic [IN_AW-1:0]    din_addr_q;
  logic [OUT_AW-1:0]   dout_addr_q;

  logic                rd, wr, busy, done;
  logic [IN_AW-1:0]    rd_addr;
  logic                last_rep, last_byte;
  logic [127:0]        cw;

  assign last_rep  = (r_q == LAST_REP);
  assign last_byte = (i_q == LAST_BYTE);

  // cw[j] = m[7] ^ <m[6:0], j>
  always_comb begin
    cw = '0;
    for (int j = 0; j < 128; j++) begin
      cw[j] = msg_q[7] ^ (^(msg_q[6:0] & 7'(j)));
    end
  end

  always_comb begin
    state_d = state_q;
    rd      = 1'b0;
    rd_addr = din_addr_q;
    wr      = 1'b0;
    busy    = 1'b0;
    done    = 1'b0;
    case (state_q)
      S_IDLE: begin
        if (bus.start_i) state_d = S_RD;
      end
      S_RD: begin
        busy    = 1'b1;
        rd      = 1'b1;
        rd_addr = '0;
        state_d = S_LAT;
      end
      S_LAT: begin
        busy    = 1'b1;
        state_d = S_WR;
      end
      S_WR: begin
        busy = 1'b1;
        wr   = 1'b1;
        if (r_q == 3'd0 && !last_byte) begin
          rd      = 1'b1;
          rd_addr = i_q + 1'b1;
        end
        if (last_rep && last_byte) state_d = S_DONE;
      end
      S_DONE: begin
        busy    = 1'b1;
        done    = 1'b1;
        state_d = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_q     <= S_IDLE;
      i_q         <= '0;
      r_q         <= '0;
      a_q         <= '0;
      msg_q       <= '0;
      msg_nxt_q   <= '0;
      din_addr_q  <= '0;
      dout_addr_q <= '0;
    end else begin
      state_q <= state_d;
      if (rd) din_addr_q  <= rd_addr;
      if (wr) dout_addr_q <= a_q;
      case (state_q)
        S_IDLE: begin
          if (bus.start_i) begin
            i_q <= '0;
            r_q <= '0;
            a_q <= '0;
          end
        end
        S_LAT: msg_q <= bus.ram_din_i;
        S_WR: begin
          a_q <= a_q + 1'b1;
          if (r_q == 3'd1 && !last_byte) msg_nxt_q <= bus.ram_din_i;
          if (last_rep) begin
            r_q   <= '0;
            msg_q <= msg_nxt_q;
            if (!last_byte) i_q <= i_q + 1'b1;
          end else begin
            r_q <= r_q + 1'b1;
          end
        end
        default: ;
      endcase
    end
  end

  // Address ports hold their last strobed value between strobes.
  assign bus.busy_o          = busy;
  assign bus.done_o          = done;
  assign bus.ram_din_rd_o    = rd;
  assign bus.ram_din_addr_o  = rd_addr;
  assign bus.ram_dout_wr_o   = wr;
  assign bus.ram_dout_o      = wr ? cw : '0;
  assign bus.ram_dout_addr_o = wr ? a_q : dout_addr_q;
endmodule

// File: doc/hqc_rmencod_top.md
Name: hqc_rmencod_top

Overview:
Reed-Muller RM(1,7) encoder with codeword duplication for the HQC concatenated-code encoder, the transmit-side counterpart of the RM decoding path. It reads N1 Reed-Solomon symbols (bytes) from an 8-bit input RAM. Each byte is encoded into a 128-bit RM codeword, and each codeword is written MULTIPLICITY times to consecutive addresses of a 128-bit output RAM. The output RAM layout matches what the RM decoder reads.

Parameters:
PARAM_SECURITY, 128, HQC security level (128/192/256).
MULTIPLICITY, (PARAM_SECURITY==128)?3:5, number of copies written per codeword.
N1, 128->46 / 192->56 / 256->90, number of input bytes.
IN_AW, 128->6 / 192->6 / 256->7, input RAM address width.
OUT_AW, 128->8 / 192->9 / 256->9, output RAM address width.

Ports:
clk_i  in  1  single clock; all logic on rising edge.
rst_i  in  1  synchronous reset, active-high.
start_i  in  1  start pulse; sampled only in IDLE.
busy_o  out  1  high while an encoding run is in progress.
done_o  out  1  one-cycle pulse at end of run.
ram_din_i  in  8  input RAM read data; valid 1 cycle after the read strobe.
ram_din_rd_o  out  1  input RAM read strobe.
ram_din_addr_o  out  IN_AW  input RAM byte address.
ram_dout_wr_o  out  1  output RAM write strobe.
ram_dout_o  out  128  output codeword; bit j is codeword bit j (bit 0 = LSB).
ram_dout_addr_o  out  OUT_AW  output RAM word address.

Behaviour:
- Interface decision (fixed): one clock (clk_i); reset rst_i is synchronous and active-high.
- Reset: the FSM goes to IDLE and all counters clear. All outputs are 0 on the first cycle after rst_i is sampled high. Reset applied mid-run aborts the run: no further reads or writes, and no done_o.
- Encoding, with m = message byte: cw[j] = m[7] XOR (XOR over k=0..6 of (m[k] AND j[k])), for j = 0..127. This is purely combinational from the registered message msg_q.
- FSM states: IDLE, RD, LAT, WR, DONE.
  - IDLE: busy_o=0. On start_i=1, go to RD. Byte index i=0, repetition r=0, out address a=0.
  - RD, 1 cycle: ram_din_rd_o=1, ram_din_addr_o=0. Go to LAT.
  - LAT, 1 cycle: msg_q <= ram_din_i. Go to WR.
  - WR, N1*MULTIPLICITY cycles, one write per cycle: ram_dout_wr_o=1, ram_dout_o=cw(msg_q), ram_dout_addr_o=a. Each cycle a increments by 1 and r increments by 1.
    - Prefetch, when i<N1-1: at r=0, assert ram_din_rd_o with ram_din_addr_o=i+1. At r=1, msg_nxt_q <= ram_din_i.
    - At r=MULTIPLICITY-1: r wraps to 0, msg_q <= msg_nxt_q, and i increments. If i=N1-1, go to DONE instead.
  - DONE, 1 cycle: done_o=1, busy_o=1. Then go to IDLE.
- busy_o is high in RD, LAT, WR and DONE.
- Total run: 3 + N1*MULTIPLICITY cycles from the first busy cycle through DONE (141 / 283 / 453).
- The last write address is N1*MULTIPLICITY-1: 137 / 279 / 449. Address a never wraps.
- ram_din_addr_o and ram_dout_addr_o hold their last value when the corresponding strobe is low. They are 0 after reset.
- ram_dout_o is 0 whenever ram_dout_wr_o=0.
- start_i outside IDLE is ignored and does not restart or extend the run. start_i in the DONE cycle is also ignored; a new start is accepted in IDLE only.
- ram_din_rd_o and ram_dout_wr_o can both be high in the same cycle (prefetch during WR r=0).
- No back-pressure: the output RAM accepts one write per cycle.

Test Plan:
- PARAM_SECURITY=128, input bytes 0x00,0x80,0x01,0x20,0x40,0xFF then 0x00 to the end. Required first 18 writes:
  - addr 0-2: 128'h0
  - addr 3-5: all ones
  - addr 6-8: 128'hAAAA_AAAA_AAAA_AAAA_AAAA_AAAA_AAAA_AAAA
  - addr 9-11: 128'hFFFFFFFF00000000FFFFFFFF00000000
  - addr 12-14: 128'hFFFFFFFFFFFFFFFF0000000000000000
  - addr 15-17: cw[j] = NOT parity(j), e.g. bit0=1, bit1=0, bit3=1
- Timing, PARAM_SECURITY=128: start pulse -> rd at addr 0 in the first busy cycle; first wr 2 cycles later; wr contiguous for 138 cycles at addresses 0..137; done_o pulse the following cycle; busy_o low the next cycle. Input reads at 0..45, each exactly once.
- PARAM_SECURITY=256, random bytes vs software model -> 450 writes, 5 identical consecutive words per byte, final address 449, run length 453 cycles.
- start_i held high throughout the run -> exactly one run, one done_o. A second start after IDLE -> a second identical run.
- rst_i asserted during the WR phase at address 20 -> next cycle all outputs 0 and FSM in IDLE; no further wr or done_o. A subsequent start gives a full correct run.
- Reset applied with start_i=1 in the same cycle -> remains IDLE, busy_o=0.
